// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

  // Booth window: two multiplier bits plus the overlap bit from the previous pair.
  localparam int WIN_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } booth_seq_state_t;

  // Width of the window counter; WIDTH/2 windows are scanned per operand.
  function automatic int cnt_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_seq_gen_product.sv
// Radix-4 Booth partial-product generator (module gen_product).
// Maps one 3-bit window to 0, +-A or +-2A. Negative products are returned
// one's-complemented with sign=1; the caller adds the missing +1.
import booth_pkg::*;

module gen_product #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIN_W-1:0] code,
  output logic [WIDTH:0]   partial_prod,
  output logic             sign
);

  logic [WIDTH:0] a1;
  logic [WIDTH:0] a2;
  logic [WIDTH:0] mag;

  assign a1 = {multiplicand[WIDTH-1], multiplicand};
  assign a2 = {multiplicand, 1'b0};

  // Select magnitude and sign for the window, then invert for negatives.
  always_comb begin
    mag  = '0;
    sign = 1'b0;
    case (code)
      3'b001, 3'b010: mag = a1;
      3'b011:         mag = a2;
      3'b100: begin
        mag  = a2;
        sign = 1'b1;
      end
      3'b101, 3'b110: begin
        mag  = a1;
        sign = 1'b1;
      end
      default: mag = '0;
    endcase
    partial_prod = sign ? ~mag : mag;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed radix-4 Booth multiplier sequencer.
// One Booth window per cycle through a single shared generator; the
// accumulator adder is inline. Optional macro BOOTH_SEQ_EARLY_TERM_EN stops
// scanning once the remaining multiplier bits are pure sign extension.
import booth_pkg::*;

module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int GW = WIDTH + 2;

  booth_seq_state_t state;

  logic [WIDTH:0]  mcand;
  logic [WIDTH:0]  mreg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [GW-1:0]   pp;
  logic            neg;
  logic [PW-1:0]   pp_ext;
  logic [CW:0]     shamt;
  logic [PW-1:0]   acc_nxt;
  logic [WIDTH:0]  mreg_nxt;
  logic            last;
  logic            done_now;

  gen_product #(
    .WIDTH(WIDTH + 1)
  ) u_gen (
    .multiplicand (mcand),
    .code         (mreg[WIN_W-1:0]),
    .partial_prod (pp),
    .sign         (neg)
  );

  // Shifted, sign-corrected partial product added into the running sum.
  always_comb begin
    pp_ext   = {{(PW-GW){pp[GW-1]}}, pp};
    shamt    = {cnt, 1'b0};
    acc_nxt  = acc + (pp_ext << shamt) + (PW'(neg) << shamt);
    mreg_nxt = {{2{mreg[WIDTH]}}, mreg[WIDTH:2]};
    last     = (cnt == CW'(WIDTH / 2 - 1));
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // Remaining windows all 000 or 111 contribute nothing.
    done_now = last || (mreg_nxt == '0) || (mreg_nxt == '1);
`else
    done_now = last;
`endif
  end

  assign out_product = acc;

  // Control FSM with registered handshake outputs and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      mcand     <= '0;
      mreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand    <= {in_multiplicand[WIDTH-1], in_multiplicand};
            mreg     <= {in_multiplier, 1'b0};
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc  <= acc_nxt;
          mreg <= mreg_nxt;
          cnt  <= cnt + CW'(1);
          if (done_now) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
